// File: rtl/onchip_mem_rr_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM (read latency 1) between two Avalon-MM requesters.
// Commands are registered onto the memory port; read data returns to the tagged requester 3 cycles after acceptance.
module onchip_mem_rr_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BE_W   = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_clken,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic              req0_c;
    logic              req1_c;
    logic              gnt_valid_c;
    logic              gnt_id_c;
    logic              last_grant;

    logic [ADDR_W-1:0] sel_address_c;
    logic              sel_read_c;
    logic              sel_write_c;
    logic [DATA_W-1:0] sel_writedata_c;
    logic [BE_W-1:0]   sel_byteenable_c;

    // Tag pipeline: stage 0 covers the memory command cycle, stage 1 the memory data cycle.
    logic [1:0]        tag_valid;
    logic [1:0]        tag_id;

    // Round-robin grant: on contention the requester that did not win last time goes first.
    always_comb begin
        req0_c      = m0_read | m0_write;
        req1_c      = m1_read | m1_write;
        gnt_valid_c = req0_c | req1_c;
        gnt_id_c    = 1'b0;
        if (req0_c && req1_c) begin
            gnt_id_c = ~last_grant;
        end else if (req1_c) begin
            gnt_id_c = 1'b1;
        end
    end

    assign m0_waitrequest = reset | ~(gnt_valid_c & ~gnt_id_c);
    assign m1_waitrequest = reset | ~(gnt_valid_c &  gnt_id_c);

    always_comb begin
        sel_address_c    = m0_address;
        sel_read_c       = m0_read;
        sel_write_c      = m0_write;
        sel_writedata_c  = m0_writedata;
        sel_byteenable_c = m0_byteenable;
        if (gnt_id_c) begin
            sel_address_c    = m1_address;
            sel_read_c       = m1_read;
            sel_write_c      = m1_write;
            sel_writedata_c  = m1_writedata;
            sel_byteenable_c = m1_byteenable;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant       <= 1'b1;
            mem_address      <= '0;
            mem_clken        <= 1'b1;
            mem_chipselect   <= 1'b0;
            mem_write        <= 1'b0;
            mem_writedata    <= '0;
            mem_byteenable   <= '0;
            tag_valid        <= 2'b00;
            tag_id           <= 2'b00;
            m0_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdata      <= '0;
            m1_readdatavalid <= 1'b0;
        end else begin
            mem_clken <= 1'b1;

            // Idle cycles drop chipselect but keep the last address/data on the bus.
            mem_chipselect <= gnt_valid_c;
            mem_write      <= gnt_valid_c & sel_write_c;
            if (gnt_valid_c) begin
                last_grant     <= gnt_id_c;
                mem_address    <= sel_address_c;
                mem_writedata  <= sel_writedata_c;
                mem_byteenable <= sel_byteenable_c;
            end

            // A read issued together with a write is dropped, so it carries no tag.
            tag_valid[0] <= gnt_valid_c & sel_read_c & ~sel_write_c;
            tag_id[0]    <= gnt_id_c;
            tag_valid[1] <= tag_valid[0];
            tag_id[1]    <= tag_id[0];

            m0_readdatavalid <= tag_valid[1] & ~tag_id[1];
            m1_readdatavalid <= tag_valid[1] &  tag_id[1];
            if (tag_valid[1] && !tag_id[1]) begin
                m0_readdata <= mem_readdata;
            end
            if (tag_valid[1] && tag_id[1]) begin
                m1_readdata <= mem_readdata;
            end
        end
    end

endmodule

// File: doc/onchip_mem_rr_arbiter.md
Name: onchip_mem_rr_arbiter

Overview:
- Shares the single-port 16-bit on-chip RAM (1K words, s1 port, read latency 1) between two Avalon-MM requesters, m0 and m1, under round-robin arbitration.
- Registers the granted command onto the memory s1 port and returns read data with a fixed, tagged latency.
- Sits between the two masters (e.g. CPU data port and a DMA) and the memory's s1 interface in my_sys.

Parameters:
- ADDR_W, 10, word address width of the memory and of both masters.
- DATA_W, 16, data width.
- BE_W, 2, byteenable width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  ADDR_W  requester 0 word address.
- m0_read  in  1  requester 0 read request.
- m0_write  in  1  requester 0 write request.
- m0_writedata  in  DATA_W  requester 0 write data.
- m0_byteenable  in  BE_W  requester 0 byte lanes.
- m0_waitrequest  out  1  high = command not accepted this cycle.
- m0_readdata  out  DATA_W  read data to requester 0.
- m0_readdatavalid  out  1  m0_readdata valid this cycle.
- m1_*  (same seven signals and directions as m0_*)  requester 1.
- mem_address  out  ADDR_W  to memory s1 address.
- mem_clken  out  1  to s1 clken.
- mem_chipselect  out  1  to s1 chipselect.
- mem_write  out  1  to s1 write.
- mem_writedata  out  DATA_W  to s1 writedata.
- mem_byteenable  out  BE_W  to s1 byteenable.
- mem_readdata  in  DATA_W  from s1 readdata (valid 1 cycle after a read command cycle).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, mem_clken=1.
  - mX_readdatavalid=0, mX_readdata=0.
  - last_grant=1, so m0 wins the first contention.
  - Tag pipeline cleared.
  - While reset is high, both mX_waitrequest=1.
- Request: reqX = mX_read | mX_write. If both are high, the cycle is a write (write wins); the read is dropped and not returned.
- Arbitration, combinational in cycle T:
  - Only reqX high -> grant X.
  - Both high -> grant the master that is not last_grant.
  - Neither high -> no grant, last_grant holds.
  - mX_waitrequest = ~(grant==X) whenever reset=0. This includes idle masters (waitrequest=1 when not requesting).
- Acceptance cycle T (grant to X):
  - last_grant<=X.
  - mem_* registered from mX_* and valid during T+1: chipselect=1, write=mX_write, address, writedata, byteenable.
  - With no grant, mem_chipselect<=0 and mem_write<=0 at T+1; other mem_* hold.
- Read return:
  - A 2-stage tag pipeline carries {valid, id}.
  - Memory returns mem_readdata at T+2. The arbiter registers it to mX_readdata with mX_readdatavalid=1 during T+3 for the tagged master only.
  - The other master's readdatavalid stays 0. Read latency is exactly 3 cycles from acceptance.
  - mX_readdata holds its last value when readdatavalid=0.
- Writes produce no response; the write completes at the memory in T+1.
- Throughput: one command per cycle. Back-to-back reads are fully pipelined, with no bubbles between grants.
- Contention: with both masters continuously requesting, grants alternate every cycle (m0, m1, m0, ...).
- Read-after-write, same address: a write accepted at T followed by a read accepted at T+1 returns the new data, because the memory orders the commands.
- Reset mid-operation: all in-flight tags are cleared, and no readdatavalid is asserted in the cycle after reset deasserts. Commands registered before reset are squashed (chipselect=0).
- mem_clken is tied high after reset. It is reserved for future gating.

Test Plan:
- Reset, then idle: both waitrequest=1 during reset; after release with no requests, mem_chipselect=0 and readdatavalid=0 for 10 cycles.
- m0 writes 0xBEEF to addr 0x005 with BE=2'b11 at T; m0 reads 0x005 at T+1 -> m0_waitrequest=0 in both cycles; m0_readdatavalid=1 with m0_readdata=0xBEEF at T+4; m1_readdatavalid stays 0.
- Byte lanes: write 0x1234 to 0x3FF, then write 0xAB00 with BE=2'b10; read -> 0xAB34.
- Contention: both masters hold reads for 6 cycles (m0 addr 0x010..., m1 addr 0x020...) -> grants m0,m1,m0,m1,m0,m1. Each master's data returns in order, 3 cycles after its grant. Each stalled master sees waitrequest=1 on alternate cycles.
- Simultaneous read+write on m1 to 0x007 with data 0x5A5A -> a single write executes and no readdatavalid follows; a later read returns 0x5A5A.
- Reset asserted 1 cycle after m0 read acceptance -> no m0_readdatavalid after reset; after release, the first contention is granted to m0.
